// File: rtl/gate_check_pkg.sv
// Shared types, truth-table constants and helpers for the gate response checker.
package gate_check_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CHECK,
    WAIT_CHANGE,
    DONE
  } state_t;

  // Expected output indexed by {a,b}
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;

  // Increment that sticks at max_val instead of wrapping
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/input_settle_detect.sv
// Tracks the last observed {a,b} vector and how long it has been stable.
module input_settle_detect #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic       i_track,
  input  logic       i_count,
  input  logic [1:0] i_vec,
  output logic [1:0] o_prev_vec,
  output logic       o_changed_c,
  output logic       o_stable_c
);

  localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_TARGET = CW'(SETTLE_CYCLES - 1);

  logic [1:0]    prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Change/stable pulses and next prev_vec/settle_cnt
  always_comb begin
    prev_d      = prev_q;
    cnt_d       = cnt_q;
    o_changed_c = (i_vec != prev_q);
    o_stable_c  = i_count && !o_changed_c && (cnt_q == CNT_TARGET);
    if (i_load) begin
      prev_d = i_vec;
      cnt_d  = '0;
    end else if (i_track && o_changed_c) begin
      prev_d = i_vec;
      cnt_d  = '0;
    end else if (i_count && (cnt_q != CNT_TARGET)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // prev_vec / settle_cnt registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev_q <= '0;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_prev_vec = prev_q;

endmodule

// File: rtl/gate_response_checker.sv
// Monitors a 2-input gate, checks settled outputs against a truth table and reports a verdict.
module gate_response_checker
  import gate_check_pkg::*;
#(
  parameter logic [3:0]  TRUTH_TABLE   = TT_AND,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned NUM_CHECKS    = 7,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_input_a,
  input  logic             i_input_b,
  input  logic             i_gate_output,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [CNT_W-1:0] o_check_count,
  output logic [CNT_W-1:0] o_error_count,
  output logic [3:0]       o_coverage,
  output logic             o_first_fail_valid,
  output logic [2:0]       o_first_fail_vec
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] chk_q, chk_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [3:0]       cov_q, cov_d;
  logic             ffv_q, ffv_d;
  logic [2:0]       ffvec_q, ffvec_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic       load;
  logic       track;
  logic       count;
  logic [1:0] prev_vec;
  logic       changed;
  logic       stable;

  input_settle_detect #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (load),
    .i_track     (track),
    .i_count     (count),
    .i_vec       ({i_input_a, i_input_b}),
    .o_prev_vec  (prev_vec),
    .o_changed_c (changed),
    .o_stable_c  (stable)
  );

  // Next state, result accumulation and registered status outputs
  always_comb begin
    state_d = state_q;
    chk_d   = chk_q;
    err_d   = err_q;
    cov_d   = cov_q;
    ffv_d   = ffv_q;
    ffvec_d = ffvec_q;
    load    = 1'b0;
    track   = (state_q == SETTLE) || (state_q == WAIT_CHANGE);
    count   = (state_q == SETTLE);

    case (state_q)
      IDLE, DONE: begin
        if (i_start) begin
          load    = 1'b1;
          chk_d   = '0;
          err_d   = '0;
          cov_d   = '0;
          ffv_d   = 1'b0;
          ffvec_d = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (i_stop)      state_d = DONE;
        else if (stable) state_d = CHECK;
      end
      CHECK: begin
        chk_d           = CNT_W'(sat_inc(32'(chk_q), CNT_MAX));
        cov_d[prev_vec] = 1'b1;
        if (i_gate_output != TRUTH_TABLE[prev_vec]) begin
          err_d = CNT_W'(sat_inc(32'(err_q), CNT_MAX));
          if (!ffv_q) begin
            ffv_d   = 1'b1;
            ffvec_d = {prev_vec, i_gate_output};
          end
        end
        if (((NUM_CHECKS != 0) && (32'(chk_d) == NUM_CHECKS)) || i_stop) state_d = DONE;
        else                                                              state_d = WAIT_CHANGE;
      end
      WAIT_CHANGE: begin
        if (i_stop)       state_d = DONE;
        else if (changed) state_d = SETTLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SETTLE) || (state_d == CHECK) || (state_d == WAIT_CHANGE);
    done_d = (state_d == DONE);
    pass_d = done_d && (err_d == '0) && (cov_d == 4'hF) && (chk_d != '0);
  end

  // State and result registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      chk_q   <= '0;
      err_q   <= '0;
      cov_q   <= '0;
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      chk_q   <= chk_d;
      err_q   <= err_d;
      cov_q   <= cov_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign o_busy             = busy_q;
  assign o_done             = done_q;
  assign o_pass             = pass_q;
  assign o_check_count      = chk_q;
  assign o_error_count      = err_q;
  assign o_coverage         = cov_q;
  assign o_first_fail_valid = ffv_q;
  assign o_first_fail_vec   = ffvec_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Randomized self-checking bench: three checker instances against a segment-level reference model.
module tb_gate_response_checker;

  localparam int S = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, stop, a, b, y;
  logic [3:0] tt_and = 4'b1000;

  logic       busy_n7, done_n7, pass_n7, ffv_n7;
  logic [7:0] chk_n7, err_n7;
  logic [3:0] cov_n7;
  logic [2:0] ffvec_n7;
  logic       busy_n0, done_n0, pass_n0, ffv_n0;
  logic [7:0] chk_n0, err_n0;
  logic [3:0] cov_n0;
  logic [2:0] ffvec_n0;
  logic       busy_st, done_st, pass_st, ffv_st;
  logic [1:0] chk_st, err_st;
  logic [3:0] cov_st;
  logic [2:0] ffvec_st;

  gate_response_checker #(.TRUTH_TABLE(4'b1000), .SETTLE_CYCLES(S), .NUM_CHECKS(7), .CNT_W(8)) u_n7 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop),
    .i_input_a(a), .i_input_b(b), .i_gate_output(y),
    .o_busy(busy_n7), .o_done(done_n7), .o_pass(pass_n7),
    .o_check_count(chk_n7), .o_error_count(err_n7), .o_coverage(cov_n7),
    .o_first_fail_valid(ffv_n7), .o_first_fail_vec(ffvec_n7));

  gate_response_checker #(.TRUTH_TABLE(4'b1000), .SETTLE_CYCLES(S), .NUM_CHECKS(0), .CNT_W(8)) u_n0 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop),
    .i_input_a(a), .i_input_b(b), .i_gate_output(y),
    .o_busy(busy_n0), .o_done(done_n0), .o_pass(pass_n0),
    .o_check_count(chk_n0), .o_error_count(err_n0), .o_coverage(cov_n0),
    .o_first_fail_valid(ffv_n0), .o_first_fail_vec(ffvec_n0));

  gate_response_checker #(.TRUTH_TABLE(4'b1000), .SETTLE_CYCLES(S), .NUM_CHECKS(0), .CNT_W(2)) u_st (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop),
    .i_input_a(a), .i_input_b(b), .i_gate_output(y),
    .o_busy(busy_st), .o_done(done_st), .o_pass(pass_st),
    .o_check_count(chk_st), .o_error_count(err_st), .o_coverage(cov_st),
    .o_first_fail_valid(ffv_st), .o_first_fail_vec(ffvec_st));

  int n_cmp = 0;
  int n_err = 0;

  // Stimulus: a run is a list of segments, each a vector held for a number of edges
  int sv[$];
  int sl[$];
  int sf[$];
  int stop_at;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_segs();
    sv.delete(); sl.delete(); sf.delete();
    stop_at = 0;
  endtask

  task automatic add_seg(input int v, input int l, input int f);
    sv.push_back(v); sl.push_back(l); sf.push_back(f);
  endtask

  // Reference: a segment is checked once when held >= S+2 edges (unless the stop lands
  // before its sampling edge); the run ends on the cap, stop, or segment list end.
  task automatic model(input int cap, input int w, output int e_chk, output int e_err,
                       output int e_cov, output int e_ffv, output int e_ffvec, output int e_pass);
    int n, ne, last, satmax;
    n = 0; ne = 0; e_cov = 0; e_ffv = 0; e_ffvec = 0;
    last = sv.size() - 1;
    for (int i = 0; i <= last; i++) begin
      int ev, ov;
      if (sl[i] < S + 2) continue;
      if (i == last && stop_at != 0 && stop_at < S + 2) continue;
      if (cap != 0 && n >= cap) break;
      n++;
      ev = int'(tt_and[sv[i]]);
      ov = ev ^ sf[i];
      if (ov != ev) begin
        ne++;
        if (e_ffv == 0) begin
          e_ffv   = 1;
          e_ffvec = sv[i] * 2 + ov;
        end
      end
      e_cov = e_cov | (1 << sv[i]);
    end
    satmax = (1 << w) - 1;
    e_chk  = (n > satmax) ? satmax : n;
    e_err  = (ne > satmax) ? satmax : ne;
    e_pass = (e_err == 0 && e_cov == 15 && e_chk != 0) ? 1 : 0;
  endtask

  // Drive the segment list; the run ends with a stop (or reset when use_rst) at stop_at
  task automatic play(input bit use_rst);
    int last;
    last = sv.size() - 1;
    for (int i = 0; i <= last; i++) begin
      logic [1:0] v;
      v = 2'(sv[i]);
      a = v[1];
      b = v[0];
      y = tt_and[v] ^ 1'(sf[i]);
      if (i == 0) start = 1'b1;
      for (int j = 1; j <= sl[i]; j++) begin
        if (i == last && stop_at == j) begin
          if (use_rst) rst = 1'b1;
          else         stop = 1'b1;
        end
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0; rst = 1'b0;
        if (i == 0 && j == 1) check_eq("busy_after_start", 32'(busy_n7), 32'd1);
      end
    end
    if (stop_at == 0 && !use_rst) begin
      stop = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic verify(input string tag);
    int c, e, cv, fv, fvec, p;
    model(7, 8, c, e, cv, fv, fvec, p);
    check_eq({tag, " n7 done"},  32'(done_n7),  32'd1);
    check_eq({tag, " n7 busy"},  32'(busy_n7),  32'd0);
    check_eq({tag, " n7 chk"},   32'(chk_n7),   32'(c));
    check_eq({tag, " n7 err"},   32'(err_n7),   32'(e));
    check_eq({tag, " n7 cov"},   32'(cov_n7),   32'(cv));
    check_eq({tag, " n7 ffv"},   32'(ffv_n7),   32'(fv));
    check_eq({tag, " n7 ffvec"}, 32'(ffvec_n7), 32'(fvec));
    check_eq({tag, " n7 pass"},  32'(pass_n7),  32'(p));
    model(0, 8, c, e, cv, fv, fvec, p);
    check_eq({tag, " n0 done"},  32'(done_n0),  32'd1);
    check_eq({tag, " n0 chk"},   32'(chk_n0),   32'(c));
    check_eq({tag, " n0 err"},   32'(err_n0),   32'(e));
    check_eq({tag, " n0 cov"},   32'(cov_n0),   32'(cv));
    check_eq({tag, " n0 ffv"},   32'(ffv_n0),   32'(fv));
    check_eq({tag, " n0 ffvec"}, 32'(ffvec_n0), 32'(fvec));
    check_eq({tag, " n0 pass"},  32'(pass_n0),  32'(p));
    model(0, 2, c, e, cv, fv, fvec, p);
    check_eq({tag, " st done"},  32'(done_st),  32'd1);
    check_eq({tag, " st chk"},   32'(chk_st),   32'(c));
    check_eq({tag, " st err"},   32'(err_st),   32'(e));
    check_eq({tag, " st cov"},   32'(cov_st),   32'(cv));
    check_eq({tag, " st pass"},  32'(pass_st),  32'(p));
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, " n7 status"}, 32'({busy_n7, done_n7, pass_n7, ffv_n7}), 32'd0);
    check_eq({tag, " n7 counts"}, 32'({chk_n7, err_n7, cov_n7, ffvec_n7}), 32'd0);
    check_eq({tag, " n0 status"}, 32'({busy_n0, done_n0, pass_n0, ffv_n0}), 32'd0);
    check_eq({tag, " n0 counts"}, 32'({chk_n0, err_n0, cov_n0, ffvec_n0}), 32'd0);
    check_eq({tag, " st status"}, 32'({busy_st, done_st, pass_st, ffv_st}), 32'd0);
    check_eq({tag, " st counts"}, 32'({chk_st, err_st, cov_st, ffvec_st}), 32'd0);
  endtask

  task automatic gen_random();
    int n, prev, v, l, last;
    clear_segs();
    n = int'($urandom_range(3, 10));
    prev = -1;
    for (int i = 0; i < n; i++) begin
      do v = int'($urandom_range(0, 3)); while (v == prev);
      prev = v;
      if ($urandom_range(0, 3) == 0) l = int'($urandom_range(1, S));
      else                           l = int'($urandom_range(S + 2, S + 8));
      add_seg(v, l, ($urandom_range(0, 4) == 0) ? 1 : 0);
    end
    last = n - 1;
    stop_at = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, sl[last]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; a = 1'b0; b = 1'b0; y = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Correct AND gate over the full sequence
    clear_segs();
    foreach (sv[i]) ;
    add_seg(0, 10, 0); add_seg(1, 10, 0); add_seg(2, 10, 0); add_seg(3, 10, 0);
    add_seg(0, 10, 0); add_seg(3, 10, 0); add_seg(2, 10, 0);
    play(1'b0);
    verify("and_ok");
    check_eq("and_ok const chk",  32'(chk_n7),  32'd7);
    check_eq("and_ok const cov",  32'(cov_n7),  32'hF);
    check_eq("and_ok const pass", 32'(pass_n7), 32'd1);

    // Output stuck at 0
    for (int i = 0; i < sv.size(); i++) sf[i] = int'(tt_and[sv[i]]);
    play(1'b0);
    verify("stuck0");
    check_eq("stuck0 const err",   32'(err_n7),   32'd2);
    check_eq("stuck0 const ffvec", 32'(ffvec_n7), 32'h6);
    check_eq("stuck0 const pass",  32'(pass_n7),  32'd0);

    // Glitch on 01 for one cycle, then 10 held
    clear_segs();
    add_seg(1, 1, 0); add_seg(2, 10, 0);
    play(1'b0);
    verify("glitch");
    check_eq("glitch const chk", 32'(chk_n0), 32'd1);
    check_eq("glitch const cov", 32'(cov_n0), 32'h4);

    // Early stop after two checks
    clear_segs();
    add_seg(0, 10, 0); add_seg(1, 10, 0);
    play(1'b0);
    verify("early_stop");
    check_eq("early_stop const cov", 32'(cov_n0), 32'h3);

    // Saturation: 11 and 00 alternating, stuck-at-0 gate
    clear_segs();
    for (int i = 0; i < 5; i++) begin
      add_seg(3, 6, 1);
      add_seg(0, 6, 0);
    end
    play(1'b0);
    verify("sat");
    check_eq("sat const err", 32'(err_st), 32'd3);
    check_eq("sat const chk", 32'(chk_st), 32'd3);

    // Reset in SETTLE after three checks, then a clean run
    clear_segs();
    add_seg(0, 10, 0); add_seg(1, 10, 0); add_seg(2, 10, 0); add_seg(3, 10, 0);
    stop_at = 2;
    play(1'b1);
    check_zero("mid_reset");
    clear_segs();
    add_seg(3, 8, 0); add_seg(2, 8, 0); add_seg(1, 8, 0); add_seg(0, 8, 0);
    play(1'b0);
    verify("after_reset");

    // Randomized runs
    for (int r = 0; r < 30; r++) begin
      gen_random();
      play(1'b0);
      verify($sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gate_response_checker.md
Name: gate_response_checker

Overview:
- Hardware self-checking monitor that sits on the output side of a 2-input gate under test.
- Observes the two gate inputs and the gate output, waits until the inputs have settled, then compares the output against a parameterised truth table.
- Accumulates check, error and coverage results and reports a pass/fail verdict.
- Lets gate designs be validated on the bench or in simulation without a hand-inspected waveform.

Parameters:
- TRUTH_TABLE, 4'b1000, expected output indexed by {a,b}; default is AND.
- SETTLE_CYCLES, 2, consecutive cycles {a,b} must be stable before sampling; minimum 1.
- NUM_CHECKS, 7, number of checks that ends the run; 0 means run until i_stop.
- CNT_W, 8, width of the counters.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- i_stop  in  1  ends the run early.
- i_input_a  in  1  gate input A, as observed.
- i_input_b  in  1  gate input B, as observed.
- i_gate_output  in  1  gate output, as observed.
- o_busy  out  1  high in SETTLE, CHECK or WAIT_CHANGE.
- o_done  out  1  high in DONE.
- o_pass  out  1  valid while o_done is high.
- o_check_count  out  CNT_W  number of checks performed.
- o_error_count  out  CNT_W  number of mismatches; saturates.
- o_coverage  out  4  bit {a,b} is set once that vector has been checked.
- o_first_fail_valid  out  1  high once a first mismatch has been captured.
- o_first_fail_vec  out  3  {a,b,out} of the first mismatch.

Behaviour:
- Reset: state IDLE; every output and internal register is 0. Reset mid-run abandons the run with no partial results kept.
- IDLE:
  - On i_start: clear counters, coverage and first-fail; load prev_vec <= {a,b}; clear settle_cnt; go to SETTLE.
  - i_stop is ignored.
- SETTLE:
  - If {a,b} != prev_vec: prev_vec <= {a,b}; settle_cnt <= 0.
  - Otherwise settle_cnt increments. When settle_cnt == SETTLE_CYCLES-1 with an unchanged vector, go to CHECK.
  - Result: the first sample happens after SETTLE_CYCLES+1 stable edges.
- CHECK (exactly one cycle):
  - Expected value = TRUTH_TABLE[prev_vec], compared against i_gate_output sampled this cycle.
  - check_count increments; o_coverage[prev_vec] is set.
  - On mismatch: error_count increments, saturating at 2^CNT_W-1. If no first fail is held yet, capture {prev_vec, i_gate_output} and set o_first_fail_valid.
  - Next state: DONE if (NUM_CHECKS != 0 and the new count == NUM_CHECKS) or i_stop; otherwise WAIT_CHANGE.
  - An input change during CHECK does not affect the current check; it is detected in WAIT_CHANGE.
- WAIT_CHANGE:
  - On {a,b} != prev_vec: prev_vec <= {a,b}; settle_cnt <= 0; go to SETTLE.
  - Holding the same vector produces no re-check.
- i_stop in SETTLE or WAIT_CHANGE: go to DONE with no check.
- DONE:
  - o_done = 1.
  - o_pass = (error_count == 0) and (o_coverage == 4'b1111) and (check_count != 0).
  - Results hold until i_start, which restarts exactly as from IDLE.
- i_start is ignored while busy.
- check_count also saturates; it never wraps.

Decomposition:
- Package gate_check_pkg contains:
  - state enum {IDLE, SETTLE, CHECK, WAIT_CHANGE, DONE};
  - truth-table constants TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110, TT_NAND=4'b0111;
  - a saturating-increment function.
- One sub-module, input_settle_detect: holds prev_vec and settle_cnt, and outputs changed and stable pulses.

Test Plan:
- Correct AND gate, TT_AND, SETTLE_CYCLES=2, vectors 00,01,10,11,00,11,10, each held 10 cycles -> o_done after the 7th check; check_count=7, error_count=0, coverage=1111, pass=1.
- Faulty gate with output stuck at 0, same sequence -> error_count=2; first_fail_vec=3'b110; first_fail_valid=1; pass=0.
- Input glitch: apply 01, change to 10 after 1 cycle, then hold -> only vector 10 is checked; check_count=1, coverage=0100.
- Early stop: NUM_CHECKS=0, vectors 00 then 01 checked, then i_stop -> done=1, check_count=2, coverage=0011, pass=0.
- i_rst asserted in SETTLE after 3 checks -> next cycle: state IDLE, all outputs 0; a subsequent i_start runs cleanly.
- Saturation: CNT_W=2, stuck-at-0 gate, vector 11 checked 5 times (alternating with 00) -> error_count saturates at 3; check_count saturates at 3; no wrap.
